// File: rtl/blink_pkg.sv
// blink_pkg: constants and types shared by the blink-rate decoder and the
// transmitter-side blinker.
//   SPEED_W      - width of a speed index
//   NUM_SPEEDS   - number of speed indices
//   RESET_SPEED  - speed index presented after reset
//   HALF_PERIOD  - half-period in clocks, indexed by speed index (0 = slowest)
//   TIMEOUT      - largest entry plus 1/16 of it; no edge within it means the link is dead
//   state_t      - decoder state
package blink_pkg;

  localparam int unsigned SPEED_W     = 4;
  localparam int unsigned NUM_SPEEDS  = 16;
  localparam int unsigned RESET_SPEED = 3;

  localparam logic [31:0] HALF_PERIOD [NUM_SPEEDS] = '{
    32'd3_000_000_000, 32'd2_500_000_000, 32'd2_000_000_000, 32'd1_500_000_000,
    32'd1_200_000_000, 32'd1_000_000_000, 32'd800_000_000,   32'd600_000_000,
    32'd400_000_000,   32'd300_000_000,   32'd200_000_000,   32'd150_000_000,
    32'd100_000_000,   32'd50_000_000,    32'd25_000_000,    32'd12_500_000
  };

  localparam logic [31:0] TIMEOUT = 32'd3_187_500_000;

  typedef enum logic {S_SYNC, S_MEAS} state_t;

  // Larger minus smaller, so the unsigned difference never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer plus delayed copy; emits a one-cycle pulse
// on either polarity of the synchronized input. Latency is identical for every
// edge, so measured intervals are preserved.
// Optional: define BLINK_DEC_GLITCH_FILTER_EN to require the synchronized input
// to be stable for 16 cycles before a transition is accepted.
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   din   - asynchronous toggle input
//   pulse - one-cycle edge pulse
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

`ifdef BLINK_DEC_GLITCH_FILTER_EN
  logic       filt;
  logic [3:0] stab_cnt;

  // filt follows sync only after sync has disagreed with it for 16 straight
  // cycles; shorter excursions reset the counter and never reach the edge path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      filt     <= 1'b0;
      stab_cnt <= '0;
      sync_d   <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      if (sync == filt) begin
        stab_cnt <= '0;
      end else if (stab_cnt == 4'd15) begin
        filt     <= sync;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + 4'd1;
      end
      sync_d <= filt;
      pulse  <= filt ^ sync_d;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync ^ sync_d;
    end
  end
`endif

endmodule

// File: rtl/blink_rate_decoder.sv
// blink_rate_decoder: measures the half-period of a toggling input and
// recovers the speed index that produced it.
// Optional: BLINK_DEC_GLITCH_FILTER_EN (see sync_edge_det).
//   clk           - 100 MHz system clock
//   rst           - asynchronous active-low reset
//   blink_in      - asynchronous toggle input
//   speed_index_o - recovered speed index
//   valid_o       - locked to speed_index_o
//   update_o      - one-cycle pulse on new lock or index change
//   timeout_o     - no edge within TIMEOUT cycles
//   leds          - one-hot cursor at speed_index_o while valid, else zero
module blink_rate_decoder
  import blink_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = 2,
  parameter int unsigned TOL_SHIFT   = 4,
  parameter int unsigned SCALE_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blink_in,
  output logic [SPEED_W-1:0] speed_index_o,
  output logic               valid_o,
  output logic               update_o,
  output logic               timeout_o,
  output logic [15:0]        leds
);

  localparam logic [31:0] TIMEOUT_S = TIMEOUT >> SCALE_SHIFT;
  localparam logic [2:0]  LOCK_N    = 3'(LOCK_COUNT);

  logic               edge_seen;
  state_t             state;
  logic [31:0]        count;
  logic [2:0]         streak;
  logic [SPEED_W-1:0] cand;

  logic [31:0]        period;
  logic [31:0]        target;
  logic               hit;
  logic [SPEED_W-1:0] hit_idx;
  logic [2:0]         next_streak;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (blink_in),
    .pulse (edge_seen)
  );

  // Ascending scan: the last match, i.e. the highest speed index, wins.
  always_comb begin
    period  = count + 32'd1;
    target  = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SPEEDS; i++) begin
      target = HALF_PERIOD[i] >> SCALE_SHIFT;
      if (abs_diff(period, target) <= (target >> TOL_SHIFT)) begin
        hit     = 1'b1;
        hit_idx = SPEED_W'(i);
      end
    end
  end

  always_comb begin
    if (hit_idx == cand) begin
      next_streak = (streak >= LOCK_N) ? LOCK_N : streak + 3'd1;
    end else begin
      next_streak = 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_SYNC;
      count         <= '0;
      streak        <= '0;
      cand          <= SPEED_W'(RESET_SPEED);
      speed_index_o <= SPEED_W'(RESET_SPEED);
      valid_o       <= 1'b0;
      update_o      <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      update_o <= 1'b0;
      if (edge_seen) begin
        // An edge takes priority over a timeout landing in the same cycle.
        count     <= '0;
        timeout_o <= 1'b0;
        if (state == S_SYNC) begin
          state <= S_MEAS;
        end else if (hit) begin
          cand   <= hit_idx;
          streak <= next_streak;
          if (next_streak == LOCK_N) begin
            valid_o       <= 1'b1;
            speed_index_o <= hit_idx;
            update_o      <= !valid_o || (speed_index_o != hit_idx);
          end
        end else begin
          streak  <= '0;
          valid_o <= 1'b0;
        end
      end else if (count == TIMEOUT_S) begin
        timeout_o <= 1'b1;
        valid_o   <= 1'b0;
        streak    <= '0;
        state     <= S_SYNC;
      end else begin
        count <= count + 32'd1;
      end
    end
  end

  assign leds = valid_o ? (16'(1) << speed_index_o) : '0;

endmodule

// File: tb/tb_blink_rate_decoder.sv
module tb_blink_rate_decoder;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b1;
  logic        blink_in = 1'b0;
  logic [3:0]  speed_index_o;
  logic        valid_o;
  logic        update_o;
  logic        timeout_o;
  logic [15:0] leds;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_last  = 0;
  int upd_cnt = 0;

`ifdef BLINK_DEC_GLITCH_FILTER_EN
  localparam int LAT = 30;
`else
  localparam int LAT = 10;
`endif

  blink_rate_decoder #(.LOCK_COUNT(2), .TOL_SHIFT(4), .SCALE_SHIFT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .blink_in      (blink_in),
    .speed_index_o (speed_index_o),
    .valid_o       (valid_o),
    .update_o      (update_o),
    .timeout_o     (timeout_o),
    .leds          (leds)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst && update_o) upd_cnt++;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    blink_in = ~blink_in;
    t_last   = cyc;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #20;
    n_tests++; if (speed_index_o !== 4'd3) begin n_fail++; $display("FAIL reset_speed: got %0d expected 3", speed_index_o); end
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_tests++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
    n_tests++; if (leds !== 16'h0000) begin n_fail++; $display("FAIL reset_leds: got %h expected 0000", leds); end
    rst = 1'b1;
    #3 clk_en = 1'b1;
    wait_cyc(1);
  endtask

  task automatic test_lock_slow();
    int base;
    base = upd_cnt;
    toggle(); wait_cyc(1525);
    toggle(); wait_cyc(LAT);
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL slow_prelock_valid: got %b expected 0", valid_o); end
    wait_cyc(1525 - LAT);
    toggle(); wait_cyc(LAT);
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL slow_valid: got %b expected 1", valid_o); end
    n_tests++; if (speed_index_o !== 4'd12) begin n_fail++; $display("FAIL slow_speed: got %0d expected 12", speed_index_o); end
    n_tests++; if (leds !== 16'h1000) begin n_fail++; $display("FAIL slow_leds: got %h expected 1000", leds); end
    n_tests++; if (upd_cnt - base !== 1) begin n_fail++; $display("FAIL slow_update: got %0d expected 1", upd_cnt - base); end
    wait_cyc(1525 - LAT);
  endtask

  task automatic test_switch_fast();
    int base;
    base = upd_cnt;
    toggle(); wait_cyc(190);
    toggle(); wait_cyc(190);
    toggle(); wait_cyc(LAT);
    n_tests++; if (speed_index_o !== 4'd15) begin n_fail++; $display("FAIL fast_speed: got %0d expected 15", speed_index_o); end
    n_tests++; if (leds !== 16'h8000) begin n_fail++; $display("FAIL fast_leds: got %h expected 8000", leds); end
    n_tests++; if (upd_cnt - base !== 1) begin n_fail++; $display("FAIL fast_update: got %0d expected 1", upd_cnt - base); end
    wait_cyc(190 - LAT);
    base = upd_cnt;
    repeat (10) begin toggle(); wait_cyc(190); end
    n_tests++; if (upd_cnt - base !== 0) begin n_fail++; $display("FAIL reconfirm_update: got %0d expected 0", upd_cnt - base); end
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL reconfirm_valid: got %b expected 1", valid_o); end
  endtask

  task automatic test_off_lut();
    int base;
    base = upd_cnt;
    wait_cyc(1068 - 190);
    toggle(); wait_cyc(LAT);
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL offlut_valid: got %b expected 0", valid_o); end
    n_tests++; if (speed_index_o !== 4'd15) begin n_fail++; $display("FAIL offlut_speed: got %0d expected 15", speed_index_o); end
    n_tests++; if (leds !== 16'h0000) begin n_fail++; $display("FAIL offlut_leds: got %h expected 0000", leds); end
    wait_cyc(1068 - LAT);
    toggle(); wait_cyc(LAT);
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL offlut2_valid: got %b expected 0", valid_o); end
    n_tests++; if (upd_cnt - base !== 0) begin n_fail++; $display("FAIL offlut_update: got %0d expected 0", upd_cnt - base); end
  endtask

  task automatic test_timeout();
    int base;
    int elapsed;
    wait_cyc(48000 - LAT);
    n_tests++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", timeout_o); end
    for (int k = 0; k < 2000; k++) begin
      if (timeout_o === 1'b1) break;
      wait_cyc(1);
    end
    elapsed = cyc - t_last;
    n_tests++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b expected 1", timeout_o); end
    n_tests++; if (elapsed < 48630 || elapsed > 48680) begin n_fail++; $display("FAIL timeout_time: got %0d expected 48630..48680", elapsed); end
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL timeout_valid: got %b expected 0", valid_o); end
    wait_cyc(100);
    base = upd_cnt;
    toggle(); wait_cyc(LAT);
    n_tests++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", timeout_o); end
    wait_cyc(190 - LAT);
    toggle(); wait_cyc(LAT);
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL resume_prelock: got %b expected 0", valid_o); end
    wait_cyc(190 - LAT);
    toggle(); wait_cyc(LAT);
    n_tests++; if (valid_o !== 1'b1 || speed_index_o !== 4'd15) begin n_fail++; $display("FAIL resume_lock: got valid %b speed %0d expected 1/15", valid_o, speed_index_o); end
    n_tests++; if (upd_cnt - base !== 1) begin n_fail++; $display("FAIL resume_update: got %0d expected 1", upd_cnt - base); end
    wait_cyc(190 - LAT);
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1;
    n_tests++; if (speed_index_o !== 4'd3) begin n_fail++; $display("FAIL areset_speed: got %0d expected 3", speed_index_o); end
    n_tests++; if (valid_o !== 1'b0 || leds !== 16'h0000) begin n_fail++; $display("FAIL areset_valid: got %b/%h expected 0/0000", valid_o, leds); end
    n_tests++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL areset_timeout: got %b expected 0", timeout_o); end
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(5);
    toggle(); wait_cyc(190);
    toggle(); wait_cyc(LAT);
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL postreset_first: got %b expected 0", valid_o); end
    wait_cyc(190 - LAT);
    toggle(); wait_cyc(LAT);
    n_tests++; if (valid_o !== 1'b1 || speed_index_o !== 4'd15) begin n_fail++; $display("FAIL postreset_lock: got valid %b speed %0d expected 1/15", valid_o, speed_index_o); end
    wait_cyc(190 - LAT);
  endtask

`ifdef BLINK_DEC_GLITCH_FILTER_EN
  task automatic test_glitch();
    toggle(); wait_cyc(5);
    blink_in = ~blink_in;
    wait_cyc(60);
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL glitch_valid: got %b expected 1", valid_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_slow();
    test_switch_fast();
    test_off_lut();
    test_timeout();
    test_async_reset();
`ifdef BLINK_DEC_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blink_rate_decoder.md
Name: blink_rate_decoder

Overview:
- Receive end of the LED blink-rate scheme: measures the half-period of an incoming toggling signal (e.g. a looped-back led0 blinker output) and recovers the 4-bit speed index that produced it.
- Speed index 0 = slowest (30 s per toggle); speed index 15 = fastest (0.125 s per toggle).
- Drives valid/update/timeout status and a one-hot LED cursor.
- Sits beside the blinker on the board top level for self-test, or on a second board driven by a wire.

Parameters:
- LOCK_COUNT, 2, consecutive matching half-periods with the same index required to lock. Legal range 1..7.
- TOL_SHIFT, 4, match tolerance is target >> TOL_SHIFT (6.25 %). Legal range 2..8.
- SCALE_SHIFT, 0, right-shift applied to every LUT value and to TIMEOUT. Simulation only; 0 on hardware.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous active-low reset (asserted when 0)
- blink_in  in  1  asynchronous toggle input
- speed_index_o  out  4  recovered speed index
- valid_o  out  1  level: locked to speed_index_o
- update_o  out  1  1-cycle pulse on new lock or index change
- timeout_o  out  1  level: no edge within TIMEOUT cycles
- leds  out  16  16'h1 << speed_index_o when valid_o, else 16'h0000

Behaviour:
- Reset values (asynchronous, no clock needed):
  - speed_index_o = 3; valid_o = 0; update_o = 0; timeout_o = 0
  - count = 0; streak = 0; state = S_SYNC
- Input path:
  - 2-FF synchronizer, then a delayed copy.
  - edge = sync ^ sync_d, i.e. both polarities.
  - Fixed 3-cycle latency, identical for every edge, so measured periods are unaffected.
- Counter:
  - 32-bit count, reset to 0 on the edge cycle, +1 every other cycle.
  - Saturates at TIMEOUT.
  - Measured period = count + 1 at the edge, so edges N clocks apart measure exactly N.
- LUT (half-period in clocks, indexed by speed index 15 down to 0):
  - 12.5M, 25M, 50M, 100M
  - 150M, 200M, 300M, 400M
  - 600M, 800M, 1.0G, 1.2G
  - 1.5G, 2.0G, 2.5G, 3.0G
- TIMEOUT = 3_187_500_000 (max entry + max entry >> 4). Fits 32 bits.
- Match rule:
  - Index i matches when |period − LUT[i]| <= LUT[i] >> TOL_SHIFT.
  - Unsigned compare with no wrap: compute the difference as larger minus smaller.
  - If several indices match, the highest speed index wins.
- S_SYNC:
  - First edge after reset or timeout → S_MEAS, count = 0.
  - No measurement is taken on this edge.
- S_MEAS, edge with a match at index i:
  - i == cand: streak++, saturating at LOCK_COUNT.
  - Otherwise: cand = i, streak = 1.
  - streak reaching LOCK_COUNT: valid_o = 1 and speed_index_o = cand on the next cycle.
  - update_o pulses in that same cycle only if valid_o was 0 or the index changed.
  - Re-confirming an unchanged locked index produces no pulse.
- S_MEAS, edge with no match: streak = 0, valid_o = 0 next cycle. speed_index_o holds its last value.
- Timeout (count reaches TIMEOUT): timeout_o = 1, valid_o = 0, streak = 0, state → S_SYNC.
- timeout_o clears on the next edge.
- An edge in the same cycle that count reaches TIMEOUT counts as an edge; the timeout is not taken.
- Reset asserted mid-operation: all state returns to reset values immediately. The first post-reset edge is unmeasured.

Optional Feature:
- Macro: BLINK_DEC_GLITCH_FILTER_EN.
- Defined:
  - The synchronized input must remain stable for 16 consecutive cycles before an edge is accepted.
  - Pulses shorter than this are ignored.
  - Latency becomes 3 + 16 cycles, constant per edge, so periods are unchanged.
- Undefined: every synchronized transition is an edge.

Decomposition:
- Package blink_pkg:
  - SPEED_W = 4, NUM_SPEEDS = 16, RESET_SPEED = 3
  - HALF_PERIOD LUT array indexed by speed index
  - TIMEOUT constant
  - state enum {S_SYNC, S_MEAS}
- The same package is to be reused by the transmitter-side blinker.
- Sub-module sync_edge_det: synchronizer, optional glitch filter and edge pulse.

Test Plan (SCALE_SHIFT = 16, so 100M → 1525, 12.5M → 190; LOCK_COUNT = 2):
- Reset: hold rst = 0, no clk edges → speed_index_o = 3, valid_o = 0, timeout_o = 0, leds = 16'h0000.
- Toggle blink_in every 1525 cycles → after the 3rd edge, valid_o = 1, speed_index_o = 12, leds = 16'h1000, exactly one update_o pulse.
- Switch to 190-cycle toggles → two edges later speed_index_o = 15, leds = 16'h8000, one update_o pulse. A further 10 edges give no pulse.
- Toggles at 1068 cycles (70M, off-LUT) → valid_o = 0 one cycle after the first such edge, speed_index_o holds 15, no update_o.
- Stop toggling → timeout_o = 1 at count == 48638 (TIMEOUT >> 16), valid_o = 0. Resume at 190 → first edge clears timeout_o, lock after 3 edges.
- Drop rst asynchronously mid-lock → outputs take reset values before the next clk edge. With the macro defined, a 5-cycle glitch produces no edge.
